seq_detect_ctrl: RTL

Controller that feeds a serial pattern-matching datapath from a parallel word stream.
- Accepts configuration (pattern, overlap mode, IRQ threshold) through a valid/ready handshake.
- Serialises input words MSB-first, one bit per prescaler tick; the tick is a single-cycle enable on the system clock, with no derived clock.
- Runs the matcher and counts matches; raises a sticky interrupt at a programmable count.

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_tick_prescaler.sv | 27 ++
 rtl/seq_detect_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and sizing helpers for the serial sequence-detect controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Counter/index width for a range of n values; never narrower than 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BITPOS_W = 32;

endpackage

// File: rtl/seq_tick_prescaler.sv
// Divides the system clock into a one-cycle enable strobe every DIVISOR enabled cycles.
module seq_tick_prescaler
  import seq_detect_pkg::*;
#(
  parameter int unsigned DIVISOR = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = idx_w(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr || o_tick)  r_cnt <= '0;
    else if (i_en)             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-serial feeder with pattern matcher, saturating match counter and sticky IRQ.
// Optional SEQ_DETECT_CTRL_BITPOS_EN adds match_bitpos (1-based bit position of last match).
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned SEQ_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIVISOR    = 1_000_000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEQ_WIDTH-1:0]  cfg_pattern,
  input  logic                  cfg_overlap,
  input  logic [CNT_WIDTH-1:0]  cfg_threshold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  bit_tick,
  output logic                  bit_out,
  output logic                  match_pulse,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic                  irq,
  input  logic                  irq_clr,
  output logic                  busy
`ifdef SEQ_DETECT_CTRL_BITPOS_EN
  , output logic [BITPOS_W-1:0] match_bitpos
`endif
);

  localparam int unsigned IDX_W  = idx_w(DATA_WIDTH);
  localparam int unsigned FILL_W = $clog2(SEQ_WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_WIDTH);

  state_e                r_state, w_state_nxt;
  logic [SEQ_WIDTH-1:0]  r_pattern, r_shift, w_shift_nxt;
  logic                  r_overlap;
  logic [CNT_WIDTH-1:0]  r_thr, r_count, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]      r_idx;
  logic [FILL_W-1:0]     r_fill, w_fill_inc;
  logic                  r_irq;
  logic w_tick, w_bit, w_last, w_match, w_cfg_hs, w_in_hs, w_cnt_sat, w_irq_set, w_shift_en;

  assign w_shift_en = (r_state == ST_SHIFT);

  seq_tick_prescaler #(.DIVISOR(DIVISOR)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_shift_en),
    .i_clr  (w_in_hs),
    .o_tick (w_tick)
  );

  assign w_last   = w_tick && (r_idx == '0);
  assign w_cfg_hs = cfg_valid && cfg_ready;
  assign w_in_hs  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_UNCFG;
    else        r_state <= w_state_nxt;
  end

  // A cfg request in IDLE takes priority over a word: in_ready drops that cycle.
  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_UNCFG: begin
        cfg_ready = 1'b1;
        if (cfg_valid) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = !cfg_valid;
        if (in_valid && !cfg_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        in_ready = w_last;
        if (w_last && !in_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_UNCFG;
    endcase
  end

  assign w_bit       = r_word[r_idx];
  assign bit_tick    = w_tick;
  assign bit_out     = w_tick & w_bit;
  assign w_shift_nxt = {r_shift[SEQ_WIDTH-2:0], w_bit};
  assign w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  assign w_match     = w_tick && (w_shift_nxt == r_pattern) && (w_fill_inc == FILL_FULL);
  assign match_pulse = w_match;
  assign w_cnt_sat   = &r_count;
  assign w_cnt_nxt   = r_count + 1'b1;
  // Only a real increment can fire the IRQ, so a saturated counter never re-triggers.
  assign w_irq_set   = w_match && !w_cnt_sat && (r_thr != '0) && (w_cnt_nxt == r_thr);
  assign match_count = r_count;
  assign irq         = r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_overlap <= 1'b0;
      r_thr     <= '0;
      r_shift   <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_irq     <= 1'b0;
      r_word    <= '0;
      r_idx     <= '0;
    end else begin
      if (w_cfg_hs) begin
        r_pattern <= cfg_pattern;
        r_overlap <= cfg_overlap;
        r_thr     <= cfg_threshold;
        r_shift   <= '0;
        r_fill    <= '0;
        r_count   <= '0;
        r_irq     <= 1'b0;
      end else begin
        if (w_tick) begin
          r_shift <= w_shift_nxt;
          r_fill  <= (w_match && !r_overlap) ? '0 : w_fill_inc;
        end
        if (w_match && !w_cnt_sat) r_count <= w_cnt_nxt;
        if (w_irq_set)             r_irq <= 1'b1;
        else if (irq_clr)          r_irq <= 1'b0;
      end
      if (w_in_hs) begin
        r_word <= in_data;
        r_idx  <= IDX_W'(DATA_WIDTH - 1);
      end else if (w_tick) begin
        r_idx  <= r_idx - 1'b1;
      end
    end
  end

`ifdef SEQ_DETECT_CTRL_BITPOS_EN
  logic [BITPOS_W-1:0] r_bitcnt, r_bitpos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt <= '0;
      r_bitpos <= '0;
    end else if (w_cfg_hs) begin
      r_bitcnt <= '0;
      r_bitpos <= '0;
    end else if (w_tick) begin
      r_bitcnt <= r_bitcnt + 1'b1;
      if (w_match) r_bitpos <= r_bitcnt + 1'b1;
    end
  end

  assign match_bitpos = r_bitpos;
`endif

endmodule
